// File: rtl/portgroup_regf_arb.sv
// portgroup_regf_arb
// Round-robin arbiter between the host bridge and the core sequencer for the
// single mem_* access port of the portgroup register file. One access is in
// flight at a time: grant (T), regf strobe (T+1), capture (T+2), rvalid (T+3).
// Build option: define PORTGROUP_REGF_ARB_LOCK_EN to add host_lock_i/core_lock_i,
// which let the last owner keep the port for atomic read-modify-write.
//
// state  | meaning
// IDLE   | port free; grant combinationally to the arbitration winner
// ISSUE  | mem_ena_o high, mem_* driven from the captured request
// RESP   | regf rdata/err captured into the owner's response registers
module portgroup_regf_arb #(
    parameter int addrwidth_p = 13,
    parameter int datawidth_p = 32
) (
    input  logic                   main_clk_i,
    input  logic                   main_rst_i,
`ifdef PORTGROUP_REGF_ARB_LOCK_EN
    input  logic                   host_lock_i,
    input  logic                   core_lock_i,
`endif
    input  logic                   host_req_i,
    input  logic [addrwidth_p-1:0] host_addr_i,
    input  logic                   host_wena_i,
    input  logic [datawidth_p-1:0] host_wdata_i,
    output logic                   host_gnt_o,
    output logic                   host_rvalid_o,
    output logic [datawidth_p-1:0] host_rdata_o,
    output logic                   host_err_o,
    input  logic                   core_req_i,
    input  logic [addrwidth_p-1:0] core_addr_i,
    input  logic                   core_wena_i,
    input  logic [datawidth_p-1:0] core_wdata_i,
    output logic                   core_gnt_o,
    output logic                   core_rvalid_o,
    output logic [datawidth_p-1:0] core_rdata_o,
    output logic                   core_err_o,
    output logic                   mem_ena_o,
    output logic [addrwidth_p-1:0] mem_addr_o,
    output logic                   mem_wena_o,
    output logic [datawidth_p-1:0] mem_wdata_o,
    input  logic [datawidth_p-1:0] mem_rdata_i,
    input  logic                   mem_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_last_host;     // 1: host owns the last grant (and the access in flight)
    logic [addrwidth_p-1:0] r_addr;
    logic                   r_wena;
    logic [datawidth_p-1:0] r_wdata;
    logic                   r_host_rvalid;
    logic [datawidth_p-1:0] r_host_rdata;
    logic                   r_host_err;
    logic                   r_core_rvalid;
    logic [datawidth_p-1:0] r_core_rdata;
    logic                   r_core_err;
    logic                   w_any_req;
    logic                   w_win_host;
    logic                   w_grant;
    logic                   w_host_locked;
    logic                   w_core_locked;

    // Winner selection: a locking last owner keeps the port, otherwise round-robin on ties.
    always_comb begin
        w_any_req = host_req_i | core_req_i;
`ifdef PORTGROUP_REGF_ARB_LOCK_EN
        w_host_locked = r_last_host & host_lock_i & host_req_i;
        w_core_locked = ~r_last_host & core_lock_i & core_req_i;
`else
        w_host_locked = 1'b0;
        w_core_locked = 1'b0;
`endif
        if (w_host_locked) begin
            w_win_host = 1'b1;
        end else if (w_core_locked) begin
            w_win_host = 1'b0;
        end else if (host_req_i && core_req_i) begin
            w_win_host = ~r_last_host;
        end else begin
            w_win_host = host_req_i;
        end
    end

    // Next-state and grant; grant is suppressed while reset is asserted so outputs stay 0.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req && !main_rst_i) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning request; these registers also drive mem_* and hold between accesses.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_last_host <= 1'b0;
            r_addr      <= '0;
            r_wena      <= 1'b0;
            r_wdata     <= '0;
        end else if (w_grant) begin
            r_last_host <= w_win_host;
            r_addr      <= w_win_host ? host_addr_i  : core_addr_i;
            r_wena      <= w_win_host ? host_wena_i  : core_wena_i;
            r_wdata     <= w_win_host ? host_wdata_i : core_wdata_i;
        end
    end

    // Route the regf response to the owner; rvalid is a single-cycle pulse, data/err hold.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_host_err    <= 1'b0;
            r_core_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_core_err    <= 1'b0;
        end else begin
            r_host_rvalid <= 1'b0;
            r_core_rvalid <= 1'b0;
            if (r_state == ST_RESP) begin
                if (r_last_host) begin
                    r_host_rvalid <= 1'b1;
                    r_host_rdata  <= r_wena ? '0 : mem_rdata_i;
                    r_host_err    <= mem_err_i;
                end else begin
                    r_core_rvalid <= 1'b1;
                    r_core_rdata  <= r_wena ? '0 : mem_rdata_i;
                    r_core_err    <= mem_err_i;
                end
            end
        end
    end

    assign host_gnt_o    = w_grant & w_win_host;
    assign core_gnt_o    = w_grant & ~w_win_host;
    assign host_rvalid_o = r_host_rvalid;
    assign host_rdata_o  = r_host_rdata;
    assign host_err_o    = r_host_err;
    assign core_rvalid_o = r_core_rvalid;
    assign core_rdata_o  = r_core_rdata;
    assign core_err_o    = r_core_err;
    assign mem_ena_o     = (r_state == ST_ISSUE);
    assign mem_addr_o    = r_addr;
    assign mem_wena_o    = r_wena;
    assign mem_wdata_o   = r_wdata;

endmodule
